// File: rtl/updown_counter_sequencer.sv
// -----------------------------------------------------------------------------
// updown_counter_sequencer
//
// Command-driven sequencer around a WIDTH-bit loadable up/down counter.
// Commands arrive over a valid/ready handshake and are executed one step per
// clock: LOAD a value, count UP n steps, count DOWN n steps, or NOP.
// Completion is reported with a one-cycle done pulse (plus aborted when an
// abort request ended the command).
//
// Optional build macro: UPDOWN_SEQ_SATURATE_EN
//   undefined : counting wraps modulo 2^WIDTH; wrap pulses after a wrapping step
//   defined   : counting saturates at 0 / 2^WIDTH-1; wrap pulses after a
//               clamped step
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  sequencer accepts a command this cycle (IDLE only)
//   cmd_op     00=LOAD, 01=UP, 10=DOWN, 11=NOP
//   cmd_arg    LOAD value or UP/DOWN step count
//   abort      terminate the executing command
//   count      current counter value
//   busy       command latched and not yet completed
//   done       one-cycle completion pulse
//   aborted    one-cycle pulse with done when abort ended the command
//   wrap       one-cycle pulse in the cycle after a wrapping/clamped step
// -----------------------------------------------------------------------------
module updown_counter_sequencer #(
    parameter int WIDTH = 4,
    parameter int OPW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             wrap
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [OPW-1:0] OP_LOAD = 2'b00;
    localparam logic [OPW-1:0] OP_UP   = 2'b01;
    localparam logic [OPW-1:0] OP_DOWN = 2'b10;
    localparam logic [OPW-1:0] OP_NOP  = 2'b11;

    state_e           state_q;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] arg_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] count_q;
    logic             cmd_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;
    logic             wrap_q;

    logic             step_up_s;
    logic             at_limit_s;
    logic [WIDTH-1:0] step_d;

    // Next counter value for one UP/DOWN step and whether it hits the limit.
    // Reaching the limit in the stepping direction is exactly the case that
    // wraps (modulo build) or is clamped (saturating build).
    always_comb begin
        step_up_s  = (op_q == OP_UP);
        at_limit_s = 1'b0;
        step_d     = count_q;
        if (step_up_s) begin
            at_limit_s = (count_q == {WIDTH{1'b1}});
        end else begin
            at_limit_s = (count_q == {WIDTH{1'b0}});
        end
`ifdef UPDOWN_SEQ_SATURATE_EN
        if (at_limit_s) begin
            step_d = count_q;
        end else if (step_up_s) begin
            step_d = count_q + WIDTH'(1);
        end else begin
            step_d = count_q - WIDTH'(1);
        end
`else
        if (step_up_s) begin
            step_d = count_q + WIDTH'(1);
        end else begin
            step_d = count_q - WIDTH'(1);
        end
`endif
    end

    // Sequencer FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= {OPW{1'b0}};
            arg_q       <= {WIDTH{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            count_q     <= {WIDTH{1'b0}};
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            wrap_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        op_q        <= cmd_op;
                        arg_q       <= cmd_arg;
                        rem_q       <= cmd_arg;
                        state_q     <= S_EXEC;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (abort) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else begin
                        case (op_q)
                            OP_LOAD: begin
                                count_q <= arg_q;
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                            OP_UP, OP_DOWN: begin
                                if (rem_q != {WIDTH{1'b0}}) begin
                                    count_q <= step_d;
                                    wrap_q  <= at_limit_s;
                                    rem_q   <= rem_q - WIDTH'(1);
                                end
                                // Last step (or n==0) completes the command.
                                if (rem_q <= WIDTH'(1)) begin
                                    state_q <= S_DONE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end
                            OP_NOP: begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                            default: begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_updown_counter_sequencer.sv
module tb_updown_counter_sequencer;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_arg;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       wrap;

    int n_tests = 0;
    int n_fail  = 0;
    int m_count = 0;

    updown_counter_sequencer #(.WIDTH(4), .OPW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .abort     (abort),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [3:0] arg;
        int         abort_at;
        logic [3:0] exp_count;
        int         exp_wraps;
    } vec_t;

`ifdef UPDOWN_SEQ_SATURATE_EN
    localparam logic [3:0] C_DN5 = 4'h0;
    localparam int         W_DN5 = 3;
    localparam logic [3:0] C_UP2 = 4'hF;
    localparam int         W_UP2 = 2;
`else
    localparam logic [3:0] C_DN5 = 4'hD;
    localparam int         W_DN5 = 1;
    localparam logic [3:0] C_UP2 = 4'h1;
    localparam int         W_UP2 = 1;
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value after k steps from c0: plain integer arithmetic, then wrap or clamp.
    function automatic int mval(input int c0, input bit up, input int k);
        int v;
        v = up ? c0 + k : c0 - k;
`ifdef UPDOWN_SEQ_SATURATE_EN
        if (v > 15) v = 15;
        if (v < 0) v = 0;
`else
        v = ((v % 16) + 16) % 16;
`endif
        return v;
    endfunction

    // Issue one command, check every cycle until back in IDLE.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] arg, input int abort_at,
                           output int fin, output int nwrap);
        int dn, d, s, k, ecnt;
        bit ab, ud, up, ewrap;
        ud = (op == OP_UP) || (op == OP_DOWN);
        up = (op == OP_UP);
        dn = (ud && arg != 4'd0) ? int'(arg) : 1;
        ab = (abort_at >= 1) && (abort_at <= dn);
        d  = ab ? abort_at : dn;
        s  = ud ? (ab ? abort_at - 1 : int'(arg)) : 0;
        nwrap = 0;
        fin = int'(count);
        for (int t = 0; t < 50 && !cmd_ready; t++) begin
            @(posedge clk); #1;
        end
        chk("ready_wait", int'(cmd_ready), 1);
        if (!cmd_ready) return;
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_arg = 4'($urandom);
        chk("accept_busy", int'(busy), 1);
        chk("accept_ready", int'(cmd_ready), 0);
        for (int j = 1; j <= d + 1; j++) begin
            abort = (j == abort_at);
            @(posedge clk); #1;
            abort = 1'b0;
            k = (j < s) ? j : s;
            if (op == OP_LOAD) ecnt = ab ? m_count : int'(arg);
            else if (ud)       ecnt = mval(m_count, up, k);
            else               ecnt = m_count;
            ewrap = ud && (j <= s) && (mval(m_count, up, j - 1) == (up ? 15 : 0));
            chk("count", int'(count), ecnt);
            chk("busy", int'(busy), int'(j < d));
            chk("done", int'(done), int'(j == d));
            chk("aborted", int'(aborted), int'(ab && j == d));
            chk("wrap", int'(wrap), int'(ewrap));
            chk("cmd_ready", int'(cmd_ready), int'(j == d + 1));
            if (wrap) nwrap++;
            if (j == d + 1) m_count = ecnt;
        end
        fin = int'(count);
    endtask

    initial begin
        vec_t vecs[13];
        int fin, nw;
        vecs[0]  = '{OP_LOAD, 4'hA, 0, 4'hA, 0};
        vecs[1]  = '{OP_UP,   4'd3, 0, 4'hD, 0};
        vecs[2]  = '{OP_LOAD, 4'h2, 0, 4'h2, 0};
        vecs[3]  = '{OP_DOWN, 4'd5, 0, C_DN5, W_DN5};
        vecs[4]  = '{OP_UP,   4'd0, 0, C_DN5, 0};
        vecs[5]  = '{OP_NOP,  4'h7, 0, C_DN5, 0};
        vecs[6]  = '{OP_LOAD, 4'h0, 0, 4'h0, 0};
        vecs[7]  = '{OP_UP,   4'd10, 3, 4'h2, 0};
        vecs[8]  = '{OP_LOAD, 4'hF, 0, 4'hF, 0};
        vecs[9]  = '{OP_UP,   4'd2, 0, C_UP2, W_UP2};
        vecs[10] = '{OP_LOAD, 4'h3, 0, 4'h3, 0};
        vecs[11] = '{OP_LOAD, 4'h9, 1, 4'h3, 0};
        vecs[12] = '{OP_DOWN, 4'd1, 1, 4'h3, 0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 4'h0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_count = 0;
        chk("rst_count", int'(count), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);
        chk("rst_wrap", int'(wrap), 0);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            run_cmd(vecs[i].op, vecs[i].arg, vecs[i].abort_at, fin, nw);
            chk($sformatf("vec%0d_final", i), fin, int'(vecs[i].exp_count));
            chk($sformatf("vec%0d_wraps", i), nw, vecs[i].exp_wraps);
        end

        // Reset in the middle of DOWN 8 from 7
        run_cmd(OP_LOAD, 4'h7, 0, fin, nw);
        cmd_valid = 1'b1; cmd_op = OP_DOWN; cmd_arg = 4'd8;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_step1", int'(count), 6);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_count", int'(count), 0);
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        @(posedge clk); #1;
        chk("midrst_done2", int'(done), 0);
        m_count = 0;

        // cmd_valid held through a whole command: re-accepted only once ready
        cmd_valid = 1'b1; cmd_op = OP_UP; cmd_arg = 4'd2;
        @(posedge clk); #1;
        chk("hold_e0_busy", int'(busy), 1);
        @(posedge clk); #1;
        chk("hold_e1_count", int'(count), 1);
        chk("hold_e1_ready", int'(cmd_ready), 0);
        @(posedge clk); #1;
        chk("hold_e2_count", int'(count), 2);
        chk("hold_e2_done", int'(done), 1);
        chk("hold_e2_ready", int'(cmd_ready), 0);
        @(posedge clk); #1;
        chk("hold_e3_ready", int'(cmd_ready), 1);
        chk("hold_e3_count", int'(count), 2);
        chk("hold_e3_busy", int'(busy), 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("hold_e4_busy", int'(busy), 1);
        chk("hold_e4_ready", int'(cmd_ready), 0);
        @(posedge clk); #1;
        chk("hold_e5_count", int'(count), 3);
        @(posedge clk); #1;
        chk("hold_e6_count", int'(count), 4);
        chk("hold_e6_done", int'(done), 1);
        @(posedge clk); #1;
        chk("hold_e7_ready", int'(cmd_ready), 1);
        m_count = 4;

        // abort while IDLE has no effect
        abort = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("idle_abort_count", int'(count), 4);
            chk("idle_abort_ready", int'(cmd_ready), 1);
            chk("idle_abort_aborted", int'(aborted), 0);
            chk("idle_abort_busy", int'(busy), 0);
        end
        abort = 1'b0;

        // Randomized commands against the model
        for (int r = 0; r < 40; r++) begin
            logic [1:0] rop;
            logic [3:0] rarg;
            int ra;
            rop  = 2'($urandom);
            rarg = 4'($urandom);
            ra   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(rarg) + 2)) : 0;
            run_cmd(rop, rarg, ra, fin, nw);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
